// File: rtl/tt_pkg.sv
// rtl/tt_pkg.sv - shared types and constants for the truth-table probe
//
// Purpose : FSM state type, row/table widths and a majority helper used by
//           tt_probe and its testbench.
package tt_pkg;

  localparam int ROW_W   = 3;  // row index width: three probe inputs
  localparam int TABLE_W = 8;  // one table bit per row

  localparam logic [ROW_W-1:0] LAST_ROW = 3'd7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } tt_state_t;

  // Two-of-three vote, used to reject a single glitched sample.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/tt_sync2.sv
// rtl/tt_sync2.sv - two-flop synchronizer for a single asynchronous bit
//
// Purpose : bring an asynchronous level into the clk domain.
// Ports   : clk   - sampling clock
//           rst_n - asynchronous active-low reset, clears both flops
//           d     - asynchronous input
//           q     - synchronized output, two clk cycles of latency
module tt_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/tt_probe.sv
// rtl/tt_probe.sv - sweeps a 3-input combinational DUT and captures its truth table
//
// Purpose : drives rows 0..7 onto probe_in1..3 (probe_in1 = MSB), lets each
//           row settle for SETTLE_CYCLES, samples the synchronized DUT output
//           and stores row i into table_out[7-i]. On completion table_out is
//           compared against the expected table latched at start.
// Macro   : TT_PROBE_MAJORITY_EN - when defined, SAMPLE lasts three cycles and
//           the row bit is the majority of the three synchronized samples.
// Ports   : clk        - clock, rising edge
//           rst_n      - asynchronous active-low reset
//           start      - level, starts a sweep when seen in IDLE
//           abort      - level, cancels an active sweep
//           expected   - reference truth table, latched at start
//           probe_in1  - DUT in1 (row bit 2)
//           probe_in2  - DUT in2 (row bit 1)
//           probe_in3  - DUT in3 (row bit 0)
//           probe_out  - DUT output, asynchronous to clk
//           busy       - sweep in progress
//           done       - one-cycle completion pulse
//           table_out  - last completed truth table
//           match      - table_out equals the latched expected table
module tt_probe
  import tt_pkg::*;
#(
  parameter int            SETTLE_CYCLES = 16,
  parameter logic [7:0]    EXPECTED_TT   = 8'h6F
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [TABLE_W-1:0] expected,
  output logic               probe_in1,
  output logic               probe_in2,
  output logic               probe_in3,
  input  logic               probe_out,
  output logic               busy,
  output logic               done,
  output logic [TABLE_W-1:0] table_out,
  output logic               match
);

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
`ifdef TT_PROBE_MAJORITY_EN
  localparam logic [7:0] SAMPLE_LAST = 8'd2;
`else
  localparam logic [7:0] SAMPLE_LAST = 8'd0;
`endif

  tt_state_t          state;
  tt_state_t          state_nxt;
  logic [7:0]         cnt;
  logic [ROW_W-1:0]   row;
  logic [TABLE_W-1:0] cap;
  logic [TABLE_W-1:0] exp_lat;
  logic               sync_q;
  logic               sample_bit;
  logic               settle_end;
  logic               sample_end;

  tt_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (probe_out),
    .q     (sync_q)
  );

`ifdef TT_PROBE_MAJORITY_EN
  logic s0;
  logic s1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0 <= 1'b0;
      s1 <= 1'b0;
    end else if (state == SAMPLE) begin
      if (cnt == 8'd0) s0 <= sync_q;
      if (cnt == 8'd1) s1 <= sync_q;
    end
  end

  assign sample_bit = maj3(s0, s1, sync_q);
`else
  assign sample_bit = sync_q;
`endif

  assign settle_end = (state == SETTLE) && (cnt == SETTLE_LAST);
  assign sample_end = (state == SAMPLE) && (cnt == SAMPLE_LAST);

  // The row register is the probe drive; it only moves on SAMPLE->SETTLE,
  // and returns to zero on abort or when the sweep has finished.
  assign {probe_in1, probe_in2, probe_in3} = row;
  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = SETTLE;
      end
      SETTLE: begin
        if (abort)           state_nxt = IDLE;
        else if (settle_end) state_nxt = SAMPLE;
      end
      SAMPLE: begin
        // abort wins even on the final row's sample
        if (abort)           state_nxt = IDLE;
        else if (sample_end) state_nxt = (row == LAST_ROW) ? DONE : SETTLE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= 8'd0;
      row       <= '0;
      cap       <= '0;
      exp_lat   <= EXPECTED_TT;
      table_out <= '0;
      match     <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;

      // cnt measures time spent in the current state
      if (state_nxt != state) cnt <= 8'd0;
      else if (state == SETTLE || state == SAMPLE) cnt <= cnt + 8'd1;

      case (state)
        IDLE: begin
          if (start) begin
            row     <= '0;
            cap     <= '0;
            exp_lat <= expected;
          end
        end
        SETTLE: begin
          if (abort) row <= '0;
        end
        SAMPLE: begin
          if (abort) begin
            row <= '0;
          end else if (sample_end) begin
            cap[LAST_ROW - row] <= sample_bit;
            if (row != LAST_ROW) row <= row + 3'd1;
          end
        end
        DONE: begin
          row <= '0;
          if (!abort) begin
            table_out <= cap;
            match     <= (cap == exp_lat);
            done      <= 1'b1;
          end
        end
        default: row <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_tt_probe.sv
// tb/tb_tt_probe.sv - randomized scoreboard bench for tt_probe
module tb_tt_probe;

  localparam int S = 16;
`ifdef TT_PROBE_MAJORITY_EN
  localparam int ROW_CYC = S + 3;
`else
  localparam int ROW_CYC = S + 1;
`endif
  localparam int LAT = 8 * ROW_CYC + 1;

  typedef struct {
    int         cyc;
    logic [7:0] tbl;
    logic       m;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] expected = 8'h00;
  logic       p1, p2, p3;
  logic       probe_out;
  logic       busy, done;
  logic [7:0] table_out;
  logic       match;

  int         mode = 0;
  logic [7:0] rnd_fn = 8'h00;
  logic       glitch = 1'b0;

  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  exp_t       sb[$];
  logic [7:0] prior_tbl = 8'h00;
  logic       prior_m = 1'b0;

  // Behavioural DUT: mode 0 is in1 | (in2 ^ in3), mode 1 is an arbitrary
  // function given as a row-indexed lookup.
  function automatic logic dut_eval(input int md, input logic [7:0] fn, input logic [2:0] r);
    if (md == 0) return r[2] | (r[1] ^ r[0]);
    return fn[r];
  endfunction

  function automatic logic [7:0] ref_table(input int md, input logic [7:0] fn);
    logic [7:0] t;
    t = 8'h00;
    for (int i = 0; i < 8; i++) t[7-i] = dut_eval(md, fn, 3'(i));
    return t;
  endfunction

  assign probe_out = dut_eval(mode, rnd_fn, {p1, p2, p3}) ^ glitch;

  tt_probe #(.SETTLE_CYCLES(S), .EXPECTED_TT(8'h6F)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .expected  (expected),
    .probe_in1 (p1),
    .probe_in2 (p2),
    .probe_in3 (p3),
    .probe_out (probe_out),
    .busy      (busy),
    .done      (done),
    .table_out (table_out),
    .match     (match)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected completion.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: actual=1 required=0 (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("table_out", {24'h0, table_out}, {24'h0, e.tbl});
        chk("match", {31'h0, match}, {31'h0, e.m});
        chk("busy_at_done", {31'h0, busy}, 32'h0);
      end
    end
  end

  // One glitched synchronizer sample per row, in the majority build only.
  int         k = 0;
  int         gm = 0;
  logic [2:0] prow = 3'd0;
  logic       pbusy = 1'b0;
  always @(negedge clk) begin
    if ({p1, p2, p3} != prow || (busy && !pbusy)) begin
      k  = 0;
      gm = $urandom_range(0, 2);
    end else begin
      k++;
    end
    prow  = {p1, p2, p3};
    pbusy = busy;
`ifdef TT_PROBE_MAJORITY_EN
    glitch = (k == S - 2 + gm);
`else
    glitch = 1'b0;
`endif
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: pending=%0d required=0", sb.size());
      sb.delete();
    end
  endtask

  // Called at a negedge; the following edge accepts start.
  task automatic launch(input int md, input logic [7:0] fn, input logic [7:0] ex,
                        input logic [7:0] req_tbl, input logic push, output int acc);
    exp_t e;
    mode     = md;
    rnd_fn   = fn;
    expected = ex;
    start    = 1'b1;
    acc      = cyc + 1;
    if (push) begin
      e.cyc = acc + LAT;
      e.tbl = req_tbl;
      e.m   = (req_tbl == ex);
      sb.push_back(e);
    end
    @(negedge clk);
    start    = 1'b0;
    expected = 8'($urandom);
  endtask

  task automatic sweep(input int md, input logic [7:0] fn, input logic [7:0] ex,
                       input logic [7:0] req_tbl);
    int acc;
    launch(md, fn, ex, req_tbl, 1'b1, acc);
    wait_drain(LAT + 20);
    prior_tbl = req_tbl;
    prior_m   = (req_tbl == ex);
    tick(2);
  endtask

  initial begin
    int         acc;
    logic [7:0] fn;
    logic [7:0] tb;
    logic [7:0] ex;

    // reset values
    tick(3);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_table", {24'h0, table_out}, 32'h0);
    chk("rst_match", {31'h0, match}, 32'h0);
    chk("rst_probes", {29'h0, p1, p2, p3}, 32'h0);
    rst_n = 1'b1;
    tick(2);

    // reference DUT against both polarities of the expected table
    sweep(0, 8'h00, 8'h6F, 8'h6F);
    sweep(0, 8'h00, 8'hF6, 8'h6F);

    // random functions, expected sometimes equal to the true table
    for (int i = 0; i < 4; i++) begin
      fn = 8'($urandom);
      tb = ref_table(1, fn);
      ex = ($urandom_range(0, 1) == 1) ? tb : 8'($urandom);
      sweep(1, fn, ex, tb);
    end

    // abort during row 4 SETTLE
    launch(0, 8'h00, 8'h6F, 8'h00, 1'b0, acc);
    tick(acc + 4 * ROW_CYC + 2 - cyc);
    chk("row4_probes", {29'h0, p1, p2, p3}, 32'h4);
    chk("row4_busy", {31'h0, busy}, 32'h1);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk("abort_busy", {31'h0, busy}, 32'h0);
    chk("abort_probes", {29'h0, p1, p2, p3}, 32'h0);
    chk("abort_table", {24'h0, table_out}, {24'h0, prior_tbl});
    chk("abort_match", {31'h0, match}, {31'h0, prior_m});
    tick(LAT + 10);

    // abort coinciding with the final row's sample
    fn = 8'($urandom);
    launch(1, fn, 8'h00, 8'h00, 1'b0, acc);
    tick(acc + 8 * ROW_CYC - 1 - cyc);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk("abort_last_busy", {31'h0, busy}, 32'h0);
    chk("abort_last_table", {24'h0, table_out}, {24'h0, prior_tbl});
    tick(LAT + 10);

    // start held high: back-to-back sweeps, mid-sweep start ignored
    begin
      exp_t e;
      mode     = 0;
      expected = 8'h6F;
      start    = 1'b1;
      acc      = cyc + 1;
      e.cyc = acc + LAT;           e.tbl = 8'h6F; e.m = 1'b1; sb.push_back(e);
      e.cyc = acc + 2 * LAT + 1;   e.tbl = 8'h6F; e.m = 1'b1; sb.push_back(e);
      tick(LAT + 22);
      start = 1'b0;
      wait_drain(LAT + 20);
      prior_tbl = 8'h6F;
      prior_m   = 1'b1;
      tick(2);
    end

    // reset in the middle of row 3
    fn = 8'($urandom);
    launch(1, fn, 8'h00, 8'h00, 1'b0, acc);
    tick(acc + 3 * ROW_CYC + 5 - cyc);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'h0, busy}, 32'h0);
    chk("mid_rst_done", {31'h0, done}, 32'h0);
    chk("mid_rst_table", {24'h0, table_out}, 32'h0);
    chk("mid_rst_match", {31'h0, match}, 32'h0);
    chk("mid_rst_probes", {29'h0, p1, p2, p3}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);
    fn = 8'($urandom);
    sweep(1, fn, ref_table(1, fn), ref_table(1, fn));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/tt_probe.md
TT_PROBE -- requirements
Module: tt_probe

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 16, meaning the cycles each input row is held before sampling; legal range 2..255.
REQ-002 SHALL have parameter EXPECTED_TT, default 8'h6F, meaning the reset value of the expected truth table.
REQ-003 SHALL have ports (clock and reset first), one per line:
- clk  input  1  single clock; all logic on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  level; begins a sweep when sampled high in IDLE
- abort  input  1  level; cancels an active sweep
- expected  input  8  truth table compared against; sampled at start
- probe_in1  output  1  drives DUT in1
- probe_in2  output  1  drives DUT in2
- probe_in3  output  1  drives DUT in3
- probe_out  input  1  DUT out, asynchronous to clk
- busy  output  1  high from the accepted start until done or abort
- done  output  1  one-cycle pulse at sweep completion
- table_out  output  8  captured truth table, held until next start
- match  output  1  table_out == latched expected, valid when done pulses and held after

Function
REQ-004 SHALL sweep rows i = 0..7 in ascending order, with {probe_in1, probe_in2, probe_in3} = i[2:0] (probe_in1 is the MSB).
REQ-005 SHALL store the sampled output of row i into table_out[7-i], so row 000 lands in the MSB (0x6F convention).
REQ-006 SHALL pass probe_out through a 2-flop synchronizer before use.
REQ-007 SHALL implement the FSM states IDLE, SETTLE, SAMPLE and DONE:
- IDLE->SETTLE on start.
- SETTLE->SAMPLE after SETTLE_CYCLES cycles.
- SAMPLE->SETTLE (next row) if i<7, else SAMPLE->DONE.
- DONE->IDLE unconditionally, after one cycle.
REQ-008 SHALL change the row outputs only at the SAMPLE->SETTLE edge and hold them stable for the whole SETTLE and SAMPLE of that row.
REQ-009 SHALL pulse done exactly 8*(SETTLE_CYCLES+1)+1 cycles after the clock edge that accepts start.
REQ-010 SHALL ignore start while busy; start held high SHALL launch a new sweep on the cycle after DONE.
REQ-011 SHALL on abort in any non-IDLE state:
- go to IDLE on the next edge;
- drive the probe outputs to 0;
- deassert busy;
- not pulse done;
- leave table_out and match unchanged from the previous completed sweep.
REQ-012 SHALL give abort priority over completion when abort and the final SAMPLE coincide.
REQ-013 SHALL clear the internal capture register at start; table_out and match SHALL update only in DONE.

Reset
REQ-014 SHALL on rst_n low, asynchronously:
- FSM to IDLE;
- probe_in1/2/3 = 0;
- busy = 0, done = 0;
- table_out = 8'h00, match = 0;
- latched expected = EXPECTED_TT;
- synchronizer flops = 0.
REQ-015 SHALL abandon a sweep in progress on reset, with no done pulse; the first start after reset release SHALL begin a full sweep from row 0.

Configuration
REQ-016 SHALL support macro TT_PROBE_MAJORITY_EN.
- When defined: SAMPLE lasts 3 cycles, the row bit is the majority of the 3 synchronized samples, and done latency becomes 8*(SETTLE_CYCLES+3)+1.
- When undefined: single-cycle SAMPLE per REQ-009.

Structure
REQ-017 SHALL place the FSM state typedef, the row-index width constant (3) and the table width constant (8) in the shared package tt_pkg.
REQ-018 SHALL instantiate the synchronizer as sub-module tt_sync2 (clk, rst_n, d, q).

Verification
REQ-019 Bench SHALL cover at least these scenarios:
- Behavioural DUT out = in1 | (in2 ^ in3), SETTLE_CYCLES=16, expected=8'h6F, start pulse -> done at cycle 137, table_out=8'h6F, match=1.
- Same DUT, expected=8'hF6 -> table_out=8'h6F, match=0.
- abort asserted in row 4 SETTLE -> busy falls next cycle, no done, table_out keeps the prior value, probes=0.
- start held high continuously -> back-to-back sweeps with done every 138 cycles; start ignored mid-sweep.
- rst_n low mid-row-3 -> all outputs at reset values immediately; the next start sweeps from row 0.
- TT_PROBE_MAJORITY_EN defined, DUT glitching one sample per row -> table_out=8'h6F, done at cycle 8*19+1=153.
